shared_bus_arbiter: RTL and testbench

- Two-requester round-robin arbiter for one shared DATA_W-bit wired-OR bus, `bus_data = (data_a & gnt_a) | (data_b & gnt_b)`.
- Grants are one-hot, so exactly one source drives the OR bus at a time.
- Burst length per grant is limited by MAX_BURST so neither requester can starve the other.
- Sits between the two bus masters and the shared bus sink.

---
 rtl/shared_bus_arbiter.sv | 97 +++++++++
 tb/tb_shared_bus_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/shared_bus_arbiter.sv
// Two-requester round-robin arbiter driving a wired-OR shared bus.
// Grants are registered and one-hot; burst length under contention is capped at MAX_BURST.
module shared_bus_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic             last_owner, last_owner_nxt;  // 0 = A, 1 = B
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Handshake: a requester holds req high while it has data; a beat is a cycle
  // with both its req and its gnt high. Dropping req ends the ownership one edge later.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        if (req_a && req_b) state_nxt = last_owner ? OWN_A : OWN_B;
        else if (req_a)     state_nxt = OWN_A;
        else if (req_b)     state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!req_a) begin
          beat_cnt_nxt = '0;
          state_nxt    = req_b ? OWN_B : IDLE;
        end else if (beat_cnt == LAST_BEAT) begin
          // Burst window ends; yield only if the other side is waiting.
          beat_cnt_nxt = '0;
          if (req_b) state_nxt = OWN_B;
        end else begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          beat_cnt_nxt = '0;
          state_nxt    = req_a ? OWN_A : IDLE;
        end else if (beat_cnt == LAST_BEAT) begin
          beat_cnt_nxt = '0;
          if (req_a) state_nxt = OWN_A;
        end else begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    last_owner_nxt = last_owner;
    if (state_nxt == OWN_A)      last_owner_nxt = 1'b0;
    else if (state_nxt == OWN_B) last_owner_nxt = 1'b1;
  end

  assign gnt_a     = (state == OWN_A);
  assign gnt_b     = (state == OWN_B);
  assign bus_data  = (data_a & {DATA_W{gnt_a}}) | (data_b & {DATA_W{gnt_b}});
  assign bus_valid = (gnt_a & req_a) | (gnt_b & req_b);

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: table-driven cycle vectors plus a hand-written async reset sequence.
// Two instances run on shared stimulus: MAX_BURST = 4 and MAX_BURST = 1.
module tb_shared_bus_arbiter;

  localparam int W  = 8;
  localparam int OW = W + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_a = 1'b0;
  logic         req_b = 1'b0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;

  logic         gnt_a4, gnt_b4, valid4;
  logic [W-1:0] bus4;
  logic         gnt_a1, gnt_b1, valid1;
  logic [W-1:0] bus1;

  always #5 clk = ~clk;

  shared_bus_arbiter #(.DATA_W(W), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a4), .gnt_b(gnt_b4), .bus_data(bus4), .bus_valid(valid4)
  );

  shared_bus_arbiter #(.DATA_W(W), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .bus_data(bus1), .bus_valid(valid1)
  );

  typedef struct {
    string        name;
    logic         sel;   // 0 = MAX_BURST 4 instance, 1 = MAX_BURST 1 instance
    logic         rst;
    logic         ra, rb;
    logic [W-1:0] da, db;
    logic         ga, gb, v;
    logic [W-1:0] d;
  } vec_t;

  vec_t          vecs[$];
  logic [OW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  // Expected bus_data follows the expected grant, even when bus_valid is low.
  task automatic add(input string name, input logic sel, input logic rst,
                     input logic ra, input logic rb,
                     input logic [W-1:0] da, input logic [W-1:0] db,
                     input logic ga, input logic gb, input logic v);
    vec_t t;
    t.name = name; t.sel = sel; t.rst = rst; t.ra = ra; t.rb = rb;
    t.da = da; t.db = db; t.ga = ga; t.gb = gb; t.v = v;
    t.d = ga ? da : (gb ? db : '0);
    vecs.push_back(t);
  endtask

  task automatic compare(input string name, input logic sel);
    logic [OW-1:0] act;
    logic [OW-1:0] e;
    act = sel ? {gnt_a1, gnt_b1, valid1, bus1} : {gnt_a4, gnt_b4, valid4, bus4};
    e = exp_q.pop_front();
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got ga=%b gb=%b valid=%b data=%h, required ga=%b gb=%b valid=%b data=%h",
               name, act[OW-1], act[OW-2], act[OW-3], act[W-1:0],
               e[OW-1], e[OW-2], e[OW-3], e[W-1:0]);
    end
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    rst_n = t.rst; req_a = t.ra; req_b = t.rb; data_a = t.da; data_b = t.db;
    exp_q.push_back({t.ga, t.gb, t.v, t.d});
    #1;
    compare(t.name, t.sel);
  endtask

  initial begin
    logic [W-1:0] r;

    // Continuous contention, MAX_BURST = 4: A for 4 beats, B for 4, then A.
    add("c_rst", 0, 0, 1, 1, 8'hA5, 8'h3C, 0, 0, 0);
    add("c_c0",  0, 1, 1, 1, 8'hA5, 8'h3C, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add("c_a",  0, 1, 1, 1, 8'hA5, 8'h3C, 1, 0, 1);
    for (int i = 5; i <= 8; i++) add("c_b",  0, 1, 1, 1, 8'hA5, 8'h3C, 0, 1, 1);
    for (int i = 9; i <= 10; i++) add("c_a2", 0, 1, 1, 1, 8'hA5, 8'h3C, 1, 0, 1);

    // Only A requesting: grant held through burst-window restarts.
    add("solo_rst", 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    r = W'($urandom_range(0, 255));
    add("solo_c0",  0, 1, 1, 0, r, 8'h3C, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      r = W'($urandom_range(0, 255));
      add("solo_a", 0, 1, 1, 0, r, 8'h3C, 1, 0, 1);
    end

    // A drops after 2 beats: direct handover to B, then all requests drop.
    add("ho_rst",   0, 0, 0, 0, 8'hA5, 8'h3C, 0, 0, 0);
    add("ho_c0",    0, 1, 1, 1, 8'hA5, 8'h3C, 0, 0, 0);
    add("ho_a1",    0, 1, 1, 1, 8'hA5, 8'h3C, 1, 0, 1);
    add("ho_a2",    0, 1, 1, 1, 8'hA5, 8'h3C, 1, 0, 1);
    add("ho_adrop", 0, 1, 0, 1, 8'hA5, 8'h3C, 1, 0, 0);
    for (int i = 4; i <= 8; i++) add("ho_b", 0, 1, 0, 1, 8'hA5, 8'h3C, 0, 1, 1);
    add("ho_bdrop", 0, 1, 0, 0, 8'hA5, 8'h3C, 0, 1, 0);
    add("ho_idle",  0, 1, 0, 0, 8'hA5, 8'h3C, 0, 0, 0);
    add("ho_idle2", 0, 1, 0, 0, 8'hA5, 8'h3C, 0, 0, 0);

    // MAX_BURST = 1: strict alternation starting with A.
    add("alt_rst", 1, 0, 1, 1, 8'hA5, 8'h3C, 0, 0, 0);
    add("alt_c0",  1, 1, 1, 1, 8'hA5, 8'h3C, 0, 0, 0);
    for (int i = 1; i <= 6; i++)
      add("alt", 1, 1, 1, 1, 8'hA5, 8'h3C, (i % 2) == 1, (i % 2) == 0, 1);

    // Reset mid-burst in OWN_B, then both request: A first.
    add("rb_rst", 0, 0, 0, 0, 8'hA5, 8'h3C, 0, 0, 0);
    add("rb_c0",  0, 1, 0, 1, 8'hA5, 8'h3C, 0, 0, 0);
    add("rb_b1",  0, 1, 1, 1, 8'hA5, 8'h3C, 0, 1, 1);
    add("rb_b2",  0, 1, 1, 1, 8'hA5, 8'h3C, 0, 1, 1);
    add("rb_rstB", 0, 0, 1, 1, 8'hA5, 8'h3C, 0, 0, 0);
    add("rb_rel", 0, 1, 1, 1, 8'hA5, 8'h3C, 0, 0, 0);
    add("rb_a",   0, 1, 1, 1, 8'hA5, 8'h3C, 1, 0, 1);

    foreach (vecs[i]) apply(vecs[i]);

    // Hand-written: A owns, reset asserted mid-cycle away from any edge,
    // then a tie must still go to A because last_owner returns to B.
    @(negedge clk);
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = 8'h5A; data_b = 8'hC3;
    @(negedge clk);
    rst_n = 1'b1; req_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back({1'b1, 1'b0, 1'b1, 8'h5A});
    compare("async_pre", 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    req_b = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h00});
    #1 compare("async_drop", 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h00});
    compare("async_rel", 0);
    @(negedge clk);
    exp_q.push_back({1'b1, 1'b0, 1'b1, 8'h5A});
    compare("async_tie_a", 0);
    @(negedge clk);
    exp_q.push_back({1'b1, 1'b0, 1'b1, 8'h5A});
    compare("async_a2", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Grants must never overlap on either instance.
  always @(negedge clk) begin
    if ((gnt_a4 && gnt_b4) || (gnt_a1 && gnt_b1)) begin
      n_err++;
      $display("FAIL onehot: got gnt4=%b%b gnt1=%b%b, required at most one grant high",
               gnt_a4, gnt_b4, gnt_a1, gnt_b1);
    end
  end

endmodule
